// File: rtl/key_event_queue_pkg.sv
// Shared types for the key event queue: FSM encoding and event word layout.
package key_event_queue_pkg;

   localparam int unsigned KEY_W = 4;
   localparam int unsigned EV_W  = KEY_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DB_PRESS = 2'd1,
      ST_HELD     = 2'd2,
      ST_DB_REL   = 2'd3
   } kq_state_t;

   // Event word: {repeat flag, key code}
   typedef struct packed {
      logic             rpt;
      logic [KEY_W-1:0] key;
   } key_ev_t;

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO; head and valid are registered, full pushes without a pop are dropped.
module key_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] head,
   output logic         drop_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  head_q, head_d;
   logic          do_pop;
   logic          do_push;
   logic          is_full;

   // Pointer/count update and next-cycle head selection
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      is_full = (count_q == CW'(DEPTH));
      do_pop  = pop && (count_q != '0);
      do_push = push && (!is_full || do_pop);
      drop_c  = push && is_full && !do_pop;

      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      valid_d = (count_d != '0);
      head_d  = valid_d ? mem_d[rd_d] : '0;
   end

   // Storage and pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         valid_q <= valid_d;
         head_q  <= head_d;
      end
   end

   assign valid = valid_q;
   assign head  = head_q;

endmodule

// File: rtl/key_event_queue.sv
// Debounces the scanned key level into press/auto-repeat events and queues them for the entry logic.
module key_event_queue
   import key_event_queue_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned HOLD_CYCLES     = 500,
   parameter int unsigned REPEAT_CYCLES   = 100,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_raw,
   input  logic             key_down,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [KEY_W-1:0] ev_key,
   output logic             ev_repeat,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic             held
);

   localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RW     = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned RELOAD = (HOLD_CYCLES > REPEAT_CYCLES) ?
                                    (HOLD_CYCLES - REPEAT_CYCLES) : 0;

   kq_state_t        state_q, state_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]    rcnt_q, rcnt_d;
   logic             push_q, push_d;
   key_ev_t          pev_q, pev_d;
   logic             ovf_q, ovf_d;
   logic             held_q, held_d;
   logic [CW-1:0]    cnt_inc;
   logic [RW-1:0]    rcnt_inc;
   logic             drop_c;
   logic [EV_W-1:0]  head_w;
   key_ev_t          head_ev;

   // Debounce FSM, repeat timer and event generation
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      rcnt_d   = rcnt_q;
      push_d   = 1'b0;
      pev_d    = '0;
      cnt_inc  = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
      rcnt_inc = (rcnt_q == RW'(HOLD_CYCLES)) ? rcnt_q : rcnt_q + RW'(1);

      case (state_q)
         ST_IDLE: begin
            if (key_down) begin
               cand_d  = key_raw;
               cnt_d   = CW'(1);
               state_d = ST_DB_PRESS;
            end
         end
         ST_DB_PRESS: begin
            if (!key_down) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (key_raw != cand_q) begin
               cand_d = key_raw;
               cnt_d  = CW'(1);
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                  push_d    = 1'b1;
                  pev_d.rpt = 1'b0;
                  pev_d.key = cand_q;
                  rcnt_d    = '0;
                  cnt_d     = '0;
                  state_d   = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (!key_down || (key_raw != cand_q)) begin
               cnt_d   = CW'(1);
               state_d = ST_DB_REL;
            end else begin
               rcnt_d = rcnt_inc;
               if ((REPEAT_EN != 0) && (rcnt_inc == RW'(HOLD_CYCLES))) begin
                  push_d    = 1'b1;
                  pev_d.rpt = 1'b1;
                  pev_d.key = cand_q;
                  rcnt_d    = RW'(RELOAD);
               end
            end
         end
         ST_DB_REL: begin
            if (key_down && (key_raw == cand_q)) begin
               // Release glitch: resume holding with the repeat timer intact
               cnt_d   = '0;
               state_d = ST_HELD;
            end else if (key_down) begin
               // Different key must go through its own full debounce
               cand_d  = key_raw;
               cnt_d   = CW'(1);
               state_d = ST_DB_PRESS;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      held_d = (state_d == ST_HELD) || (state_d == ST_DB_REL);
      // A drop in the same cycle as a clear leaves the flag set
      ovf_d  = drop_c ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         push_q  <= 1'b0;
         pev_q   <= '0;
         ovf_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
         push_q  <= push_d;
         pev_q   <= pev_d;
         ovf_q   <= ovf_d;
         held_q  <= held_d;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EV_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (pev_q),
      .pop       (ev_ready),
      .valid     (ev_valid),
      .head      (head_w),
      .drop_c    (drop_c)
   );

   assign head_ev   = head_w;
   assign ev_key    = head_ev.key;
   assign ev_repeat = head_ev.rpt;
   assign ovf       = ovf_q;
   assign held      = held_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: vector table for single presses plus hand sequences for repeat, overflow and reset.
module tb_key_event_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_raw;
   logic       key_down;
   logic       ev_ready;
   logic       ovf_clr;

   logic       ev_valid, ev_repeat, ovf, held;
   logic [3:0] ev_key;
   logic       nr_valid, nr_repeat, nr_ovf, nr_held;
   logic [3:0] nr_key;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic       kd;
      logic [3:0] key;
      logic       rdy;
      logic       clr;
      logic       e_valid;
      logic [3:0] e_key;
      logic       e_rpt;
      logic       e_held;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   key_event_queue #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (16),
      .REPEAT_CYCLES   (8),
      .REPEAT_EN       (1),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_raw),
      .key_down  (key_down),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_key    (ev_key),
      .ev_repeat (ev_repeat),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .held      (held)
   );

   key_event_queue #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (16),
      .REPEAT_CYCLES   (8),
      .REPEAT_EN       (0),
      .FIFO_DEPTH      (4)
   ) dut_nr (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_raw),
      .key_down  (key_down),
      .ev_valid  (nr_valid),
      .ev_ready  (ev_ready),
      .ev_key    (nr_key),
      .ev_repeat (nr_repeat),
      .ovf       (nr_ovf),
      .ovf_clr   (ovf_clr),
      .held      (nr_held)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic kd, input logic [3:0] key, input logic rdy, input logic clr,
                      input logic ev, input logic [3:0] ek, input logic er,
                      input logic eh, input logic eo);
      vec_t v;
      v.kd = kd; v.key = key; v.rdy = rdy; v.clr = clr;
      v.e_valid = ev; v.e_key = ek; v.e_rpt = er; v.e_held = eh; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   // Press key k long enough to be accepted, then release fully back to idle
   task automatic press(input logic [3:0] k);
      key_down = 1'b1;
      key_raw  = k;
      repeat (5) step();
      key_down = 1'b0;
      key_raw  = 4'd0;
      repeat (4) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [0:17] bpat;
      logic        exp_v;
      int          waited;

      // Clean press: key 5 for 10 cycles, then release
      for (int i = 1; i <= 10; i++)
         add(1'b1, 4'd5, 1'b1, 1'b0, (i == 5), 4'd5, 1'b0, (i >= 4), 1'b0);
      for (int i = 1; i <= 4; i++)
         add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, (i < 4), 1'b0);
      // Bounce on press, then a 2-cycle release glitch while held, then release
      bpat = 18'b101101111100110000;
      for (int i = 1; i <= 18; i++)
         add(bpat[i-1], 4'd3, 1'b1, 1'b0, (i == 10), 4'd3, 1'b0,
             (i >= 9 && i <= 17), 1'b0);
      // Code change during debounce: 7,7 then 2 stable
      for (int i = 1; i <= 8; i++)
         add(1'b1, (i <= 2) ? 4'd7 : 4'd2, 1'b1, 1'b0, (i == 7), 4'd2, 1'b0, (i >= 6), 1'b0);
      for (int i = 1; i <= 4; i++)
         add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, (i < 4), 1'b0);

      rst      = 1'b1;
      key_raw  = 4'd0;
      key_down = 1'b0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset.ev_valid",  32'(ev_valid),  0);
      check("reset.ev_key",    32'(ev_key),    0);
      check("reset.ev_repeat", 32'(ev_repeat), 0);
      check("reset.ovf",       32'(ovf),       0);
      check("reset.held",      32'(held),      0);

      foreach (vecs[i]) begin
         key_down = vecs[i].kd;
         key_raw  = vecs[i].key;
         ev_ready = vecs[i].rdy;
         ovf_clr  = vecs[i].clr;
         step();
         check($sformatf("vec%0d.valid", i), 32'(ev_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d.held",  i), 32'(held),     32'(vecs[i].e_held));
         check($sformatf("vec%0d.ovf",   i), 32'(ovf),      32'(vecs[i].e_ovf));
         if (vecs[i].e_valid) begin
            check($sformatf("vec%0d.key", i), 32'(ev_key),    32'(vecs[i].e_key));
            check($sformatf("vec%0d.rpt", i), 32'(ev_repeat), 32'(vecs[i].e_rpt));
         end
      end

      // Auto-repeat: key 9 held 40 cycles; pushes at 4, 20, 28, 36 appear one cycle later
      rst = 1'b1;
      #2;
      rst = 1'b0;
      key_down = 1'b1;
      key_raw  = 4'd9;
      ev_ready = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         exp_v = (k == 5) || (k == 21) || (k == 29) || (k == 37);
         check($sformatf("rep%0d.valid", k), 32'(ev_valid), 32'(exp_v));
         check($sformatf("rep%0d.held", k), 32'(held), 32'(k >= 4));
         if (exp_v) begin
            check($sformatf("rep%0d.key", k), 32'(ev_key), 9);
            check($sformatf("rep%0d.rpt", k), 32'(ev_repeat), 32'(k != 5));
         end
         check($sformatf("norep%0d.valid", k), 32'(nr_valid), 32'(k == 5));
         if (k == 5) check("norep.rpt", 32'(nr_repeat), 0);
      end
      key_down = 1'b0;
      key_raw  = 4'd0;
      repeat (4) step();
      check("rep.release_held", 32'(held), 0);

      // Overflow: five presses with the consumer stalled
      ev_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         press(4'(k));
         if (k == 4) check("ovf.after4", 32'(ovf), 0);
      end
      check("ovf.after5", 32'(ovf), 1);
      ev_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf.pop%0d.valid", k), 32'(ev_valid), 1);
         check($sformatf("ovf.pop%0d.key", k), 32'(ev_key), 32'(k));
         check($sformatf("ovf.pop%0d.rpt", k), 32'(ev_repeat), 0);
         step();
      end
      check("ovf.drained", 32'(ev_valid), 0);
      check("ovf.sticky", 32'(ovf), 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf.cleared", 32'(ovf), 0);

      // Async reset in the middle of a debounce with two events queued
      ev_ready = 1'b0;
      press(4'd1);
      press(4'd2);
      key_down = 1'b1;
      key_raw  = 4'd7;
      step();
      step();
      check("arst.pre_valid", 32'(ev_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst.valid", 32'(ev_valid), 0);
      check("arst.held",  32'(held),     0);
      check("arst.ovf",   32'(ovf),      0);
      check("arst.key",   32'(ev_key),   0);
      key_down = 1'b0;
      key_raw  = 4'd0;
      step();
      rst = 1'b0;
      key_down = 1'b1;
      key_raw  = 4'd8;
      ev_ready = 1'b1;
      waited   = 0;
      while (!ev_valid && waited < 20) begin
         step();
         waited++;
      end
      check("arst.fresh_latency", 32'(waited), 5);
      check("arst.fresh_key", 32'(ev_key), 8);
      check("arst.fresh_rpt", 32'(ev_repeat), 0);
      step();
      check("arst.fresh_single", 32'(ev_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits between the keypad scanner / key-value mapper and the display/entry logic.
- Turns the raw scanned key level (4-bit code plus a pressed flag) into clean, debounced key events:
  - one press event per physical press;
  - optional auto-repeat events while the key is held.
- Events are buffered in a small show-ahead FIFO with valid/ready handshake, so the digit-entry logic never misses or double-counts a keystroke.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable cycles needed to accept a press or release (>=2)
HOLD_CYCLES, 500, cycles a key must stay held after press acceptance before the first repeat event
REPEAT_CYCLES, 100, cycles between subsequent repeat events
REPEAT_EN, 1, 1 enables auto-repeat, 0 suppresses all repeat events
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
key_raw  in  4  key code from scanner, meaningful only while key_down=1
key_down  in  1  raw level: a key is currently detected
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head this cycle
ev_key  out  4  key code of head event
ev_repeat  out  1  1 = auto-repeat event, 0 = initial press
ovf  out  1  sticky: an event was dropped because FIFO full
ovf_clr  in  1  clears ovf
held  out  1  debounced key-held level (state HELD)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; all counters 0; FIFO empty; ev_valid=0, ev_key=0, ev_repeat=0, ovf=0, held=0.
- Reset mid-operation discards all queued events and any press in progress.
- States:
  - IDLE: waits for key_down=1. On key_down=1, latch cand=key_raw, cnt=1, go to DB_PRESS.
  - DB_PRESS:
    - key_down=0 -> IDLE.
    - key_raw!=cand -> cand=key_raw, cnt=1, stay.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, push {cand, repeat=0}, go to HELD, rcnt=0.
  - HELD: held=1.
    - key_down=0 or key_raw!=cand -> DB_REL, cnt=1.
    - Otherwise rcnt++. If REPEAT_EN:
      - first repeat push when rcnt==HOLD_CYCLES;
      - then every REPEAT_CYCLES, by reloading rcnt=HOLD_CYCLES-REPEAT_CYCLES on each push.
  - DB_REL: held stays 1.
    - key_down=1 and key_raw==cand -> back to HELD. rcnt is preserved; no new press event.
    - key_down=1 and key_raw!=cand -> DB_PRESS with new cand, cnt=1. This acceptance path is the only one: a different key is only accepted after its own full debounce.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Press latency: key_down stable from cycle 0 -> push at cycle DEBOUNCE_CYCLES -> ev_valid=1 at cycle DEBOUNCE_CYCLES+1.
- FIFO:
  - Show-ahead: ev_key/ev_repeat are valid whenever ev_valid=1.
  - Pop when ev_valid & ev_ready.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - Push while full with no pop: event dropped, ovf<=1.
  - Push and pop in the same cycle while full: both occur, no drop, count unchanged.
  - Push and pop in the same cycle while empty: not a bypass; the event appears next cycle.
  - ev_ready while empty: ignored.
- ovf: ovf_clr clears it. If a drop and ovf_clr occur in the same cycle, the drop wins and ovf=1.
- Counters saturate and never wrap. cnt is clog2(DEBOUNCE_CYCLES+1) bits wide. rcnt is sized for HOLD_CYCLES.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, DB_PRESS=1, HELD=2, DB_REL=3.
  - Event field widths: key 4 bits, event word 5 bits {repeat, key}.
- One sub-module: key_event_fifo, a parameterised show-ahead sync FIFO with push/pop/full/empty/drop. The top of this block holds the debounce FSM and repeat timer only.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, FIFO_DEPTH=4.
- Clean press: key_down=1, key_raw=5 held 10 cycles, ev_ready=1 -> exactly one event {key=5, repeat=0}, ev_valid high for one cycle at cycle 5; no repeats; held=1 from cycle 4.
- Bounce: key_down toggles 1,0,1,1,0,1,1,1,1 with key_raw=3 -> no event until 4 consecutive high cycles, then one event key=3. Release glitch of 2 low cycles while held -> no second event.
- Code change during debounce: key_raw 7,7,2,2,2,2 with key_down=1 -> single event key=2, none for 7.
- Auto-repeat: key 9 held 40 cycles, ev_ready=1 -> press at cycle 4, repeats at cycles 20, 28, 36 with ev_repeat=1. With REPEAT_EN=0 -> only the press event.
- Overflow: ev_ready=0, five press/release cycles of keys 1..5 -> FIFO holds 1,2,3,4; ovf=1 after the 5th press. Then ev_ready=1 -> pops 1,2,3,4 in order, then ev_valid=0. ovf_clr -> ovf=0.
- Async reset: assert rst mid-DB_PRESS with 2 events queued -> ev_valid=0, held=0, ovf=0 immediately without a clock edge. After deassert, the next valid press produces a fresh event.
